// File: rtl/gate_op_pipe.sv
// Bitwise gate-operation unit feeding a small in-order result buffer.
// Results are registered at the buffer head; y reads zero whenever no result is held.
module gate_op_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [15:0]      out_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       op_i,
    input logic [WIDTH-1:0] a_i,
    input logic [WIDTH-1:0] b_i
  );
    logic [WIDTH-1:0] r;
    case (op_i)
      3'd0:    r = ~a_i;
      3'd1:    r = a_i & b_i;
      3'd2:    r = a_i | b_i;
      3'd3:    r = a_i ^ b_i;
      3'd4:    r = ~(a_i & b_i);
      3'd5:    r = ~(a_i | b_i);
      3'd6:    r = ~(a_i ^ b_i);
      3'd7:    r = a_i;
      default: r = a_i;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [15:0]      out_count_q, out_count_d;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] res_s;

  // Handshakes, pointer/occupancy update and look-ahead of the next head value.
  always_comb begin
    in_ready    = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    res_s       = gate_f(op, a, b);
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    out_count_d = out_count_q;
    y_d         = {WIDTH{1'b0}};

    if (!rst && (cnt_q < DEPTH_C)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    push_s = in_valid && in_ready;
    pop_s  = out_valid_q && out_ready && !rst;

    if (push_s) begin
      wr_d = wr_q + AW'(1'b1);
    end else begin
      wr_d = wr_q;
    end

    if (pop_s) begin
      rd_d        = rd_q + AW'(1'b1);
      out_count_d = out_count_q + 16'd1;
    end else begin
      rd_d        = rd_q;
      out_count_d = out_count_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1'b1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1'b1);
      default: cnt_d = cnt_q;
    endcase

    out_valid_d = (cnt_d != '0);
    // The incoming result becomes the head when it lands where the read pointer will point.
    if (cnt_d == '0) begin
      y_d = {WIDTH{1'b0}};
    end else if (push_s && (wr_q == rd_d)) begin
      y_d = res_s;
    end else begin
      y_d = mem_q[rd_d];
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      out_count_q <= 16'd0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_count_q <= out_count_d;
    end
  end

  // Result storage; contents are masked by out_valid so need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= res_s;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_count = out_count_q;

endmodule
